reg_bank_32: RTL and testbench

- Write-side counterpart of the processor's 32:1 read multiplexer.
- Holds 32 x 32-bit registers and decodes a 5-bit write select into one-hot write enables.
- Exposes all register contents as one flattened bus, which feeds the existing read mux.
- Adds a sequenced bulk-clear engine (one register per cycle) with a busy flag. The ALU/regfile layer uses it for context reset without a global reset.

---
 rtl/reg_bank_pkg.sv | 13 +
 rtl/decoder_32.sv | 17 +
 rtl/reg_bank_32.sv | 107 ++++++++++
 tb/tb_reg_bank_32.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared constants and state encoding for the 32-entry register bank.
package reg_bank_pkg;

  localparam int WIDTH    = 32;
  localparam int SEL_BITS = 5;
  localparam int DEPTH    = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/decoder_32.sv
// Combinational select-to-one-hot decoder for the register bank write path.
module decoder_32
  import reg_bank_pkg::*;
(
  input  logic [SEL_BITS-1:0] sel_i,
  input  logic                en_i,
  output logic [DEPTH-1:0]    onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[sel_i] = 1'b1;
    end
  end

endmodule

// File: rtl/reg_bank_32.sv
// 32 x 32-bit register bank with one-per-cycle bulk clear sequencer.
// Build option REG_BANK_ZERO_REG_EN hardwires register 0 to zero.
module reg_bank_32
  import reg_bank_pkg::*;
(
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic                      wr_en_i,
  input  logic [SEL_BITS-1:0]       wr_sel_i,
  input  logic [WIDTH-1:0]          wr_data_i,
  input  logic                      clr_req_i,
  output logic                      wr_ack_o,
  output logic                      busy_o,
  output logic [SEL_BITS-1:0]       clr_idx_o,
  output logic [WIDTH*DEPTH-1:0]    q_flat_o
);

  state_e                state_q;
  logic                  wr_ack_q;
  logic                  busy_q;
  logic [SEL_BITS-1:0]   clr_idx_q;
  logic [WIDTH-1:0]      regs_q [DEPTH];
  logic [DEPTH-1:0]      wr_onehot;
  logic                  wr_go;
  logic                  clr_active;

  // clr_req wins over a same-cycle write, and writes are locked out while clearing
  assign wr_go      = (state_q == IDLE) && wr_en_i && !clr_req_i;
  assign clr_active = (state_q == CLEAR);

  decoder_32 u_wr_dec (
    .sel_i    (wr_sel_i),
    .en_i     (wr_go),
    .onehot_o (wr_onehot)
  );

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      wr_ack_q  <= 1'b0;
      busy_q    <= 1'b0;
      clr_idx_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          wr_ack_q <= wr_go;
          if (clr_req_i) begin
            state_q   <= CLEAR;
            busy_q    <= 1'b1;
            clr_idx_q <= '0;
          end
        end
        CLEAR: begin
          wr_ack_q <= 1'b0;
          if (clr_idx_q == SEL_BITS'(DEPTH - 1)) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            clr_idx_q <= '0;
          end else begin
            clr_idx_q <= clr_idx_q + SEL_BITS'(1);
          end
        end
        default: begin
          state_q   <= IDLE;
          wr_ack_q  <= 1'b0;
          busy_q    <= 1'b0;
          clr_idx_q <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (reset_i) begin
        regs_q[i] <= '0;
      end else if (wr_onehot[i]) begin
`ifdef REG_BANK_ZERO_REG_EN
        if (i != 0) begin
          regs_q[i] <= wr_data_i;
        end
`else
        regs_q[i] <= wr_data_i;
`endif
      end else if (clr_active && (clr_idx_q == SEL_BITS'(i))) begin
        regs_q[i] <= '0;
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
`ifdef REG_BANK_ZERO_REG_EN
    if (g == 0) begin : g_zero
      assign q_flat_o[g*WIDTH +: WIDTH] = '0;
    end else begin : g_reg
      assign q_flat_o[g*WIDTH +: WIDTH] = regs_q[g];
    end
`else
    assign q_flat_o[g*WIDTH +: WIDTH] = regs_q[g];
`endif
  end

  assign wr_ack_o  = wr_ack_q;
  assign busy_o    = busy_q;
  assign clr_idx_o = clr_idx_q;

endmodule

// File: tb/tb_reg_bank_32.sv
// Directed self-checking bench for reg_bank_32 (honours REG_BANK_ZERO_REG_EN).
module tb_reg_bank_32;
  import reg_bank_pkg::*;

  logic                   clock_i;
  logic                   reset_i;
  logic                   wr_en_i;
  logic [SEL_BITS-1:0]    wr_sel_i;
  logic [WIDTH-1:0]       wr_data_i;
  logic                   clr_req_i;
  logic                   wr_ack_o;
  logic                   busy_o;
  logic [SEL_BITS-1:0]    clr_idx_o;
  logic [WIDTH*DEPTH-1:0] q_flat_o;

  int errors = 0;
  int checks = 0;
  logic [WIDTH-1:0] exp_regs [DEPTH];
  int cnt;

  reg_bank_32 dut (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .wr_en_i   (wr_en_i),
    .wr_sel_i  (wr_sel_i),
    .wr_data_i (wr_data_i),
    .clr_req_i (clr_req_i),
    .wr_ack_o  (wr_ack_o),
    .busy_o    (busy_o),
    .clr_idx_o (clr_idx_o),
    .q_flat_o  (q_flat_o)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [WIDTH*DEPTH-1:0] obs,
                       input logic [WIDTH*DEPTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH*DEPTH-1:0] exp_flat();
    logic [WIDTH*DEPTH-1:0] r;
    r = '0;
    for (int i = 0; i < DEPTH; i++) r[i*WIDTH +: WIDTH] = exp_regs[i];
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] slice(input int i);
    return q_flat_o[i*WIDTH +: WIDTH];
  endfunction

  task automatic model_write(input int sel, input logic [WIDTH-1:0] data);
`ifdef REG_BANK_ZERO_REG_EN
    if (sel != 0) exp_regs[sel] = data;
`else
    exp_regs[sel] = data;
`endif
  endtask

  task automatic do_write(input int sel, input logic [WIDTH-1:0] data);
    wr_en_i   = 1'b1;
    wr_sel_i  = SEL_BITS'(sel);
    wr_data_i = data;
    model_write(sel, data);
    step();
    wr_en_i = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1; wr_en_i = 1'b0; wr_sel_i = '0; wr_data_i = '0; clr_req_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) exp_regs[i] = '0;
    step(); step();
    reset_i = 1'b0;
    step(); step();
    check("rst_q_flat", q_flat_o, '0);
    check("rst_busy", busy_o, 0);
    check("rst_wr_ack", wr_ack_o, 0);
    check("rst_clr_idx", clr_idx_o, 0);

    // fill every register, one write per cycle
    for (int i = 0; i < DEPTH; i++) begin
      wr_en_i   = 1'b1;
      wr_sel_i  = SEL_BITS'(i);
      wr_data_i = WIDTH'(i + 100);
      model_write(i, WIDTH'(i + 100));
      step();
      check($sformatf("fill_ack_%0d", i), wr_ack_o, 1);
      check($sformatf("fill_slice_%0d", i), slice(i), exp_regs[i]);
    end
    wr_en_i = 1'b0;
    step();
    check("fill_ack_drop", wr_ack_o, 0);
    check("fill_q_flat", q_flat_o, exp_flat());

    // bulk clear with a write attempt to reg 5 after it has been cleared
    clr_req_i = 1'b1;
    step();
    clr_req_i = 1'b0;
    check("clr_busy_start", busy_o, 1);
    cnt = 0;
    while (busy_o && cnt < 40) begin
      check($sformatf("clr_idx_%0d", cnt), clr_idx_o, cnt);
      if (cnt == 7) begin
        wr_en_i = 1'b1; wr_sel_i = 5'd5; wr_data_i = 32'hDEAD;
      end
      step();
      wr_en_i = 1'b0;
      if (cnt < DEPTH) exp_regs[cnt] = '0;
      check($sformatf("clr_ack_%0d", cnt), wr_ack_o, 0);
      if (cnt < DEPTH) check($sformatf("clr_slice_%0d", cnt), slice(cnt), 0);
      if (cnt < DEPTH - 1) check($sformatf("clr_next_%0d", cnt + 1), slice(cnt + 1), exp_regs[cnt + 1]);
      cnt++;
    end
    check("clr_busy_cycles", cnt, DEPTH);
    check("clr_idx_idle", clr_idx_o, 0);
    check("clr_q_flat", q_flat_o, '0);
    step();
    check("clr_no_restart", busy_o, 0);

    // clr_req and wr_en together: clear wins
    clr_req_i = 1'b1; wr_en_i = 1'b1; wr_sel_i = 5'd3; wr_data_i = 32'h1234;
    step();
    clr_req_i = 1'b0; wr_en_i = 1'b0;
    check("prio_ack", wr_ack_o, 0);
    check("prio_busy", busy_o, 1);
    check("prio_slice3", slice(3), 0);
    cnt = 0;
    while (busy_o && cnt < 40) begin
      step();
      cnt++;
    end
    check("prio_clear_len", cnt, DEPTH);

    // reset in the middle of a clear
    do_write(20, 32'hAAAA);
    do_write(31, 32'h5555);
    check("pre_rst_q_flat", q_flat_o, exp_flat());
    clr_req_i = 1'b1;
    step();
    clr_req_i = 1'b0;
    cnt = 0;
    while (clr_idx_o != 5'd10 && cnt < 40) begin
      step();
      cnt++;
    end
    check("midrst_reach_10", clr_idx_o, 10);
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) exp_regs[i] = '0;
    check("midrst_busy", busy_o, 0);
    check("midrst_clr_idx", clr_idx_o, 0);
    check("midrst_q_flat", q_flat_o, '0);
    step();
    check("midrst_no_resume", busy_o, 0);

    // back-to-back overwrite of reg 7
    wr_en_i = 1'b1; wr_sel_i = 5'd7; wr_data_i = 32'hFFFFFFFF;
    model_write(7, 32'hFFFFFFFF);
    step();
    check("ovw_slice7_a", slice(7), 32'hFFFFFFFF);
    check("ovw_flat_a", q_flat_o, exp_flat());
    check("ovw_ack_a", wr_ack_o, 1);
    wr_data_i = 32'h1;
    model_write(7, 32'h1);
    step();
    wr_en_i = 1'b0;
    check("ovw_slice7_b", slice(7), 32'h1);
    check("ovw_flat_b", q_flat_o, exp_flat());
    check("ovw_ack_b", wr_ack_o, 1);
    step();
    check("ovw_ack_end", wr_ack_o, 0);

    // register 0 write: acked either way, stored only without the zero-reg option
    do_write(0, 32'hCAFE);
    check("reg0_ack", wr_ack_o, 1);
    check("reg0_slice", slice(0), exp_regs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
